// File: rtl/pc_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// pc_fetch: F-stage PC register and one-outstanding instruction fetch sequencer
// with MIPS delay-slot branches and cancel redirects.  Rev 1.0
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] npc,
   input  logic        branch,
   input  logic        cancel,
   input  logic        stall,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        f_valid,
   output logic [31:0] f_pc,
   output logic [31:0] f_inst,
   output logic        f_adel
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] fetch_pc_d;
   logic [31:0] req_pc_q;
   logic [31:0] tgt_q;
   logic        pend_q;
   logic        discard_q;
   logic        f_valid_q;
   logic [31:0] f_pc_q;
   logic [31:0] f_inst_q;
   logic        f_adel_q;

   logic        misal;
   logic        capture;
   logic        hs;
   logic        advance;

   always_comb begin
      misal      = |fetch_pc_q[1:0];
      capture    = branch & ~stall & ~cancel;
      inst_req   = (state_q == S_REQ) & ~cancel & ~misal;
      inst_addr  = fetch_pc_q;
      hs         = inst_req & inst_addr_ok;
      advance    = (state_q == S_REQ) & ~cancel & (hs | misal);
      // A branch seen in the same cycle as the delay-slot handshake redirects at once
      fetch_pc_d = capture ? npc : (pend_q ? tgt_q : fetch_pc_q + 32'd4);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 32'd0;
         tgt_q      <= 32'd0;
         pend_q     <= 1'b0;
         discard_q  <= 1'b0;
         f_valid_q  <= 1'b0;
         f_pc_q     <= 32'd0;
         f_inst_q   <= 32'd0;
         f_adel_q   <= 1'b0;
      end else if (cancel) begin
         fetch_pc_q <= npc;
         pend_q     <= 1'b0;
         f_valid_q  <= 1'b0;
         if (state_q == S_WAIT) begin
            if (inst_data_ok) begin
               discard_q <= 1'b0;
               state_q   <= S_REQ;
            end else begin
               discard_q <= 1'b1;
            end
         end else begin
            state_q <= S_REQ;
         end
      end else begin
         if (advance) begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= 1'b0;
         end else if (capture) begin
            pend_q <= 1'b1;
            tgt_q  <= npc;
         end
         case (state_q)
            S_REQ: begin
               if (misal) begin
                  f_pc_q    <= fetch_pc_q;
                  f_inst_q  <= 32'd0;
                  f_adel_q  <= 1'b1;
                  f_valid_q <= 1'b1;
                  state_q   <= S_FULL;
               end else if (hs) begin
                  req_pc_q <= fetch_pc_q;
                  state_q  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  if (discard_q) begin
                     discard_q <= 1'b0;
                     state_q   <= S_REQ;
                  end else begin
                     f_pc_q    <= req_pc_q;
                     f_inst_q  <= inst_rdata;
                     f_adel_q  <= 1'b0;
                     f_valid_q <= 1'b1;
                     state_q   <= S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (!stall) begin
                  f_valid_q <= 1'b0;
                  state_q   <= S_REQ;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

   assign f_valid = f_valid_q;
   assign f_pc    = f_pc_q;
   assign f_inst  = f_inst_q;
   assign f_adel  = f_adel_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// tb_pc_fetch: directed stimulus, memory responder and scoreboard for pc_fetch.
module tb_pc_fetch;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] npc;
   logic        branch, cancel, stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = 32'd0;
   logic        f_valid;
   logic [31:0] f_pc, f_inst;
   logic        f_adel;

   pc_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .resetn(resetn), .npc(npc), .branch(branch), .cancel(cancel), .stall(stall),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst), .f_adel(f_adel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fexp_t;

   logic [31:0] exp_req[$];
   fexp_t       exp_f[$];
   int          checks = 0;
   int          failures = 0;
   int          n_deliv = 0;
   int          mem_cnt = 0;
   int          mem_dly = 1;
   logic [31:0] mem_addr = 32'd0;

   function automatic logic [31:0] mkinst(input logic [31:0] a);
      return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=none expected=event", tag);
   endtask

   task automatic push_f(input logic [31:0] pc);
      exp_f.push_back('{pc: pc, inst: mkinst(pc), adel: 1'b0});
   endtask

   task automatic push_adel(input logic [31:0] pc);
      exp_f.push_back('{pc: pc, inst: 32'd0, adel: 1'b1});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_deliv(input int target);
      int k = 0;
      while (n_deliv < target && k < 60) begin
         step();
         k++;
      end
      if (n_deliv < target) fail_now("deliv_timeout");
   endtask

   // Memory responder and scoreboard; observes mid-cycle, drives data at negedge
   always @(negedge clk) begin
      fexp_t e;
      if (!resetn) begin
         inst_data_ok = 1'b0;
         mem_cnt = 0;
      end else begin
         inst_data_ok = 1'b0;
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               inst_data_ok = 1'b1;
               inst_rdata = mkinst(mem_addr);
            end
         end
         if (inst_req && inst_addr_ok) begin
            if (exp_req.size() == 0) fail_now("unexpected_req");
            else chk("req_addr", inst_addr, exp_req.pop_front());
            mem_addr = inst_addr;
            mem_cnt = mem_dly;
         end
         if (f_valid && !stall && !cancel) begin
            n_deliv++;
            if (exp_f.size() == 0) fail_now("unexpected_deliv");
            else begin
               e = exp_f.pop_front();
               chk("f_pc", f_pc, e.pc);
               chk("f_inst", f_inst, e.inst);
               chk("f_adel", {31'd0, f_adel}, {31'd0, e.adel});
            end
         end
      end
   end

   initial begin
      #200000;
      fail_now("global_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "simulation time limit");
   end

   initial begin
      int k;
      resetn = 1'b0; npc = 32'd0; branch = 1'b0; cancel = 1'b0; stall = 1'b0;
      inst_addr_ok = 1'b0;
      repeat (3) step();
      chk("rst_addr", inst_addr, RESET_PC);
      chk("rst_fvalid", {31'd0, f_valid}, 32'd0);
      chk("rst_fpc", f_pc, 32'd0);
      chk("rst_finst", f_inst, 32'd0);
      chk("rst_fadel", {31'd0, f_adel}, 32'd0);

      // Sequential fetch after reset
      exp_req.push_back(32'hBFC0_0000); exp_req.push_back(32'hBFC0_0004);
      exp_req.push_back(32'hBFC0_0008);
      push_f(32'hBFC0_0000); push_f(32'hBFC0_0004); push_f(32'hBFC0_0008);
      resetn = 1'b1;
      inst_addr_ok = 1'b1;
      #1 chk("req_after_reset", {31'd0, inst_req}, 32'd1);
      wait_deliv(3);
      inst_addr_ok = 1'b0;

      // Branch captured without handshake: delay slot 0C, then target
      exp_req.push_back(32'hBFC0_000C); exp_req.push_back(32'hBFC0_0100);
      exp_req.push_back(32'hBFC0_0104);
      push_f(32'hBFC0_000C); push_f(32'hBFC0_0100); push_f(32'hBFC0_0104);
      branch = 1'b1; npc = 32'hBFC0_0100;
      step();
      branch = 1'b0; npc = 32'd0;
      inst_addr_ok = 1'b1;
      wait_deliv(6);
      inst_addr_ok = 1'b0;

      // Branch coincident with the delay-slot handshake
      exp_req.push_back(32'hBFC0_0108); exp_req.push_back(32'hBFC0_0200);
      push_f(32'hBFC0_0108); push_f(32'hBFC0_0200);
      inst_addr_ok = 1'b1; branch = 1'b1; npc = 32'hBFC0_0200;
      step();
      branch = 1'b0; npc = 32'd0;
      wait_deliv(8);
      inst_addr_ok = 1'b0;

      // Stall while FULL, with an ignored branch pulse
      exp_req.push_back(32'hBFC0_0204);
      push_f(32'hBFC0_0204);
      stall = 1'b1; inst_addr_ok = 1'b1;
      k = 0;
      while (!f_valid && k < 20) begin step(); k++; end
      if (!f_valid) fail_now("stall_fill_timeout");
      inst_addr_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_fvalid", {31'd0, f_valid}, 32'd1);
         chk("stall_fpc", f_pc, 32'hBFC0_0204);
         chk("stall_finst", f_inst, mkinst(32'hBFC0_0204));
         chk("stall_req", {31'd0, inst_req}, 32'd0);
         branch = (i == 2);
         npc = (i == 2) ? 32'hBFC0_0300 : 32'd0;
         step();
      end
      branch = 1'b0; npc = 32'd0;
      exp_req.push_back(32'hBFC0_0208); exp_req.push_back(32'hBFC0_020C);
      push_f(32'hBFC0_0208); push_f(32'hBFC0_020C);
      stall = 1'b0; inst_addr_ok = 1'b1;
      wait_deliv(11);
      inst_addr_ok = 1'b0;

      // Cancel with a request outstanding; late data must be dropped
      exp_req.push_back(32'hBFC0_0210);
      mem_dly = 3; inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0; cancel = 1'b1; npc = 32'hBFC0_0380;
      #1 chk("cancel_wait_req", {31'd0, inst_req}, 32'd0);
      step();
      cancel = 1'b0; npc = 32'd0;
      repeat (4) begin
         chk("cancel_drop_fvalid", {31'd0, f_valid}, 32'd0);
         step();
      end
      chk("cancel_next_req", {31'd0, inst_req}, 32'd1);
      chk("cancel_next_addr", inst_addr, 32'hBFC0_0380);
      mem_dly = 1;
      exp_req.push_back(32'hBFC0_0380);
      push_f(32'hBFC0_0380);
      inst_addr_ok = 1'b1;
      wait_deliv(12);
      inst_addr_ok = 1'b0;

      // Cancel and branch together: cancel wins, no delay slot
      inst_addr_ok = 1'b1; branch = 1'b1; cancel = 1'b1; npc = 32'h8000_0180;
      #1 chk("cancel_branch_req", {31'd0, inst_req}, 32'd0);
      step();
      branch = 1'b0; cancel = 1'b0; npc = 32'd0;
      exp_req.push_back(32'h8000_0180); exp_req.push_back(32'h8000_0184);
      push_f(32'h8000_0180); push_f(32'h8000_0184);
      wait_deliv(14);
      inst_addr_ok = 1'b0;

      // Misaligned branch target produces an address-error slot, no request
      exp_req.push_back(32'h8000_0188);
      push_f(32'h8000_0188); push_adel(32'hBFC0_0102);
      inst_addr_ok = 1'b1; branch = 1'b1; npc = 32'hBFC0_0102;
      step();
      branch = 1'b0; npc = 32'd0;
      wait_deliv(16);
      cancel = 1'b1; npc = 32'hFFFF_FFFC; inst_addr_ok = 1'b0;
      #1 chk("misal_cancel_req", {31'd0, inst_req}, 32'd0);
      step();
      cancel = 1'b0; npc = 32'd0;

      // PC wraps modulo 2^32
      exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0000_0000);
      push_f(32'hFFFF_FFFC); push_f(32'h0000_0000);
      inst_addr_ok = 1'b1;
      wait_deliv(18);
      inst_addr_ok = 1'b0;

      // Reset mid-transaction drops the outstanding fetch
      exp_req.push_back(32'h0000_0004);
      mem_dly = 3; inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      step();
      resetn = 1'b0;
      #1;
      chk("midrst_addr", inst_addr, RESET_PC);
      chk("midrst_fvalid", {31'd0, f_valid}, 32'd0);
      step(); step();
      resetn = 1'b1;
      repeat (5) step();
      chk("postrst_fvalid", {31'd0, f_valid}, 32'd0);
      chk("postrst_req", {31'd0, inst_req}, 32'd1);
      chk("postrst_addr", inst_addr, RESET_PC);
      chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
      chk("f_queue_empty", 32'(exp_f.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
